// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: default word width and FSM state encoding.
package spi_pkg;

  localparam int SPI_WORD_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } spi_periph_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// One pin synchronizer chain with a history flop for single-cycle rise/fall detection.
module spi_sync_edge #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Reset to the pin's idle level so leaving reset never fakes an edge on an idle bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_LEVEL}};
      hist_q <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI peripheral: oversamples SCLK/CS_n/MOSI on clock_i and shifts words MSB first,
// supporting multi-word frames and reporting frames cut short mid-word.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int WORD_WIDTH  = SPI_WORD_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  SCLK_i,
  input  logic                  CS_n_i,
  input  logic                  MOSI_i,
  output logic                  MISO_o,
  input  logic [WORD_WIDTH-1:0] tx_data_i,
  output logic                  tx_load_o,
  output logic [WORD_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  abort_o
);

  localparam int CNT_W  = $clog2(WORD_WIDTH + 1);
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SET_W  = $clog2(SETTLE + 1);

  spi_periph_state_t state_q, state_d;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_level, mosi_level;
  logic sclk_level_unused, mosi_rise_unused, mosi_fall_unused;

  logic [WORD_WIDTH-1:0] shift_tx_q, shift_rx_q, rx_data_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [SET_W-1:0]      settle_cnt_q;
  logic                  word_done_q, fall_hold_q, armed_q;
  logic                  tx_load_q, rx_valid_q, abort_q;
  logic                  start, cs_end, do_rise, do_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
    .clk(clock_i), .rst(reset_i), .pin(SCLK_i),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
    .clk(clock_i), .rst(reset_i), .pin(CS_n_i),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  // Same depth as SCLK so MOSI is seen exactly as it stood at the matching SCLK edge
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
    .clk(clock_i), .rst(reset_i), .pin(MOSI_i),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    cs_end  = 1'b0;
    do_rise = 1'b0;
    do_fall = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && (cs_fall || fall_hold_q)) begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A chip-select release masks any SCLK edge seen in the same cycle
        if (cs_rise) begin
          cs_end  = 1'b1;
          state_d = FINISH;
        end else begin
          do_rise = sclk_rise;
          do_fall = sclk_fall;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // After reset, wait for the chains to flush and CS_n to read high, so a chip select
  // still held low from before reset cannot start a frame.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      settle_cnt_q <= '0;
      armed_q      <= 1'b0;
    end else if (!armed_q) begin
      if (settle_cnt_q != SET_W'(SETTLE)) begin
        settle_cnt_q <= settle_cnt_q + 1'b1;
      end else if (cs_level) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      fall_hold_q <= 1'b0;
      tx_load_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      tx_load_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
      fall_hold_q <= (state_q == FINISH) && cs_fall;

      if (start) begin
        shift_tx_q  <= tx_data_i;
        shift_rx_q  <= '0;
        bit_cnt_q   <= '0;
        word_done_q <= 1'b0;
        tx_load_q   <= 1'b1;
      end

      if (cs_end && (bit_cnt_q != '0)) begin
        abort_q <= 1'b1;
      end

      if (do_rise) begin
        shift_rx_q <= {shift_rx_q[WORD_WIDTH-2:0], mosi_level};
        if (bit_cnt_q == CNT_W'(WORD_WIDTH - 1)) begin
          rx_data_q   <= {shift_rx_q[WORD_WIDTH-2:0], mosi_level};
          rx_valid_q  <= 1'b1;
          bit_cnt_q   <= '0;
          word_done_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end

      // The first falling edge after a full word presents the next word's MSB
      if (do_fall) begin
        if (word_done_q) begin
          shift_tx_q  <= tx_data_i;
          tx_load_q   <= 1'b1;
          word_done_q <= 1'b0;
        end else begin
          shift_tx_q <= shift_tx_q << 1;
        end
      end
    end
  end

  assign busy_o     = (state_q == SHIFT);
  assign MISO_o     = busy_o & shift_tx_q[WORD_WIDTH-1];
  assign tx_load_o  = tx_load_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign abort_o    = abort_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a 64 MHz system clock with a 1 MHz mode-0 controller
// (64 clock_i cycles per SCLK period) modelled by tasks.
`timescale 1ps/1ps
module tb_spi_peripheral;

  localparam int W    = 16;
  localparam int HALF = 32;
  localparam int SYNC = 2;

  logic         clock_i = 1'b0;
  logic         reset_i;
  logic         SCLK_i, CS_n_i, MOSI_i;
  logic         MISO_o;
  logic [W-1:0] tx_data_i;
  logic         tx_load_o;
  logic [W-1:0] rx_data_o;
  logic         rx_valid_o, busy_o, abort_o;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_valid_cnt, tx_load_cnt, abort_cnt, busy_hi_cnt, miso_hi_cnt;
  int cyc = 0;
  int drive_cyc, last_valid_cyc;
  logic [W-1:0] rx_log [4];

  spi_peripheral #(.WORD_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .SCLK_i(SCLK_i), .CS_n_i(CS_n_i),
    .MOSI_i(MOSI_i), .MISO_o(MISO_o), .tx_data_i(tx_data_i), .tx_load_o(tx_load_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .busy_o(busy_o), .abort_o(abort_o)
  );

  always #7812 clock_i = ~clock_i;

  always @(posedge clock_i) cyc <= cyc + 1;

  // Pulse and level monitor, sampled on the inactive clock edge
  always @(negedge clock_i) begin
    if (rx_valid_o) begin
      if (rx_valid_cnt < 4) rx_log[rx_valid_cnt] = rx_data_o;
      rx_valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (tx_load_o) tx_load_cnt++;
    if (abort_o) abort_cnt++;
    if (busy_o) busy_hi_cnt++;
    if (MISO_o) miso_hi_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  task automatic clear_counts();
    rx_valid_cnt = 0; tx_load_cnt = 0; abort_cnt = 0; busy_hi_cnt = 0; miso_hi_cnt = 0;
  endtask

  task automatic begin_frame();
    CS_n_i = 1'b0;
  endtask

  // Each bit: drop SCLK and present MOSI, wait, sample MISO, raise SCLK, wait
  task automatic send_bits(input logic [31:0] data, input int nbits, output logic [31:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      SCLK_i = 1'b0;
      MOSI_i = data[nbits-1-i];
      wait_clk(HALF);
      miso = {miso[30:0], MISO_o};
      drive_cyc = cyc;
      SCLK_i = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic end_frame();
    SCLK_i = 1'b0;
    CS_n_i = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; SCLK_i = 1'b0; CS_n_i = 1'b1; MOSI_i = 1'b0; tx_data_i = '0;
    clear_counts();
    wait_clk(3);
    n_checks++; if (MISO_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_miso: got %b expected 0", MISO_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (rx_data_o !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_rx_data: got %h expected 0000", rx_data_o); end
    n_checks++; if (rx_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid_o); end
    n_checks++; if (tx_load_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tx_load: got %b expected 0", tx_load_o); end
    n_checks++; if (abort_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_abort: got %b expected 0", abort_o); end
    reset_i = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic test_single_word();
    logic [31:0] m;
    clear_counts();
    tx_data_i = 16'hA5C3;
    begin_frame();
    send_bits(32'h1234, 16, m);
    wait_clk(8);
    n_checks++; if ((last_valid_cyc - drive_cyc) > SYNC + 2 || (last_valid_cyc - drive_cyc) < 1) begin n_fail++; $display("[TB] FAIL single_latency: got %0d cycles expected 1..%0d", last_valid_cyc - drive_cyc, SYNC + 2); end
    end_frame();
    n_checks++; if (m[15:0] !== 16'hA5C3) begin n_fail++; $display("[TB] FAIL single_miso: got %h expected a5c3", m[15:0]); end
    n_checks++; if (rx_data_o !== 16'h1234) begin n_fail++; $display("[TB] FAIL single_rx_data: got %h expected 1234", rx_data_o); end
    n_checks++; if (rx_valid_cnt !== 1) begin n_fail++; $display("[TB] FAIL single_rx_valid_count: got %0d expected 1", rx_valid_cnt); end
    n_checks++; if (abort_cnt !== 0) begin n_fail++; $display("[TB] FAIL single_abort_count: got %0d expected 0", abort_cnt); end
    n_checks++; if (tx_load_cnt !== 1) begin n_fail++; $display("[TB] FAIL single_tx_load_count: got %0d expected 1", tx_load_cnt); end
    n_checks++; if (busy_hi_cnt == 0 || busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy: got %0d busy cycles, final %b, expected >0 and 0", busy_hi_cnt, busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] m1, m2;
    clear_counts();
    tx_data_i = 16'h1111;
    begin_frame();
    send_bits(32'h000000BE, 8, m1);
    tx_data_i = 16'h2222;
    send_bits(32'h00EF0001, 24, m2);
    end_frame();
    n_checks++; if ({m1[7:0], m2[23:0]} !== 32'h11112222) begin n_fail++; $display("[TB] FAIL two_word_miso: got %h expected 11112222", {m1[7:0], m2[23:0]}); end
    n_checks++; if (rx_valid_cnt !== 2) begin n_fail++; $display("[TB] FAIL two_word_rx_valid_count: got %0d expected 2", rx_valid_cnt); end
    n_checks++; if (rx_log[0] !== 16'hBEEF) begin n_fail++; $display("[TB] FAIL two_word_first: got %h expected beef", rx_log[0]); end
    n_checks++; if (rx_log[1] !== 16'h0001) begin n_fail++; $display("[TB] FAIL two_word_second: got %h expected 0001", rx_log[1]); end
    n_checks++; if (tx_load_cnt !== 2) begin n_fail++; $display("[TB] FAIL two_word_tx_load_count: got %0d expected 2", tx_load_cnt); end
    n_checks++; if (abort_cnt !== 0) begin n_fail++; $display("[TB] FAIL two_word_abort_count: got %0d expected 0", abort_cnt); end
  endtask

  task automatic test_abort();
    logic [31:0] m;
    clear_counts();
    tx_data_i = 16'hFFFF;
    begin_frame();
    send_bits(32'h0000005A, 7, m);
    end_frame();
    n_checks++; if (abort_cnt !== 1) begin n_fail++; $display("[TB] FAIL abort_count: got %0d expected 1", abort_cnt); end
    n_checks++; if (rx_valid_cnt !== 0) begin n_fail++; $display("[TB] FAIL abort_rx_valid_count: got %0d expected 0", rx_valid_cnt); end
    n_checks++; if (rx_data_o !== 16'h0001) begin n_fail++; $display("[TB] FAIL abort_rx_hold: got %h expected 0001", rx_data_o); end
    clear_counts();
    begin_frame();
    send_bits(32'h000000FF, 16, m);
    end_frame();
    n_checks++; if (rx_data_o !== 16'h00FF) begin n_fail++; $display("[TB] FAIL abort_next_rx_data: got %h expected 00ff", rx_data_o); end
    n_checks++; if (rx_valid_cnt !== 1) begin n_fail++; $display("[TB] FAIL abort_next_rx_valid_count: got %0d expected 1", rx_valid_cnt); end
    n_checks++; if (abort_cnt !== 0) begin n_fail++; $display("[TB] FAIL abort_next_abort_count: got %0d expected 0", abort_cnt); end
  endtask

  task automatic test_idle_noise();
    clear_counts();
    CS_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      SCLK_i = 1'b1; MOSI_i = i[0];
      wait_clk(8);
      SCLK_i = 1'b0;
      wait_clk(8);
    end
    wait_clk(8);
    n_checks++; if (busy_hi_cnt !== 0) begin n_fail++; $display("[TB] FAIL idle_busy: got %0d busy cycles expected 0", busy_hi_cnt); end
    n_checks++; if (miso_hi_cnt !== 0) begin n_fail++; $display("[TB] FAIL idle_miso: got %0d high cycles expected 0", miso_hi_cnt); end
    n_checks++; if (rx_valid_cnt + tx_load_cnt + abort_cnt !== 0) begin n_fail++; $display("[TB] FAIL idle_pulses: got %0d pulses expected 0", rx_valid_cnt + tx_load_cnt + abort_cnt); end
    n_checks++; if (rx_data_o !== 16'h00FF) begin n_fail++; $display("[TB] FAIL idle_rx_hold: got %h expected 00ff", rx_data_o); end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] m;
    clear_counts();
    tx_data_i = 16'hC3C3;
    begin_frame();
    send_bits(32'h00000155, 9, m);
    reset_i = 1'b1;
    wait_clk(1);
    n_checks++; if ({MISO_o, busy_o, rx_valid_o, tx_load_o, abort_o} !== 5'b0) begin n_fail++; $display("[TB] FAIL midreset_flags: got %b expected 00000", {MISO_o, busy_o, rx_valid_o, tx_load_o, abort_o}); end
    n_checks++; if (rx_data_o !== 16'h0000) begin n_fail++; $display("[TB] FAIL midreset_rx_data: got %h expected 0000", rx_data_o); end
    wait_clk(4);
    clear_counts();
    reset_i = 1'b0;
    send_bits(32'h0000007F, 7, m);
    end_frame();
    n_checks++; if (busy_hi_cnt !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_restart: got %0d busy cycles expected 0", busy_hi_cnt); end
    n_checks++; if (abort_cnt + rx_valid_cnt !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_pulses: got %0d pulses expected 0", abort_cnt + rx_valid_cnt); end
    begin_frame();
    send_bits(32'h00008001, 16, m);
    end_frame();
    n_checks++; if (rx_data_o !== 16'h8001) begin n_fail++; $display("[TB] FAIL midreset_rx_data_after: got %h expected 8001", rx_data_o); end
    n_checks++; if (rx_valid_cnt !== 1) begin n_fail++; $display("[TB] FAIL midreset_rx_valid_count: got %0d expected 1", rx_valid_cnt); end
    n_checks++; if (abort_cnt !== 0) begin n_fail++; $display("[TB] FAIL midreset_abort_count: got %0d expected 0", abort_cnt); end
  endtask

  task automatic test_cs_sclk_collision();
    logic [31:0] m;
    clear_counts();
    tx_data_i = 16'h0F0F;
    begin_frame();
    send_bits(32'h00007FFF, 15, m);
    SCLK_i = 1'b0; MOSI_i = 1'b1;
    wait_clk(HALF);
    SCLK_i = 1'b1; CS_n_i = 1'b1;
    wait_clk(HALF);
    SCLK_i = 1'b0;
    wait_clk(HALF);
    n_checks++; if (abort_cnt !== 1) begin n_fail++; $display("[TB] FAIL collision_abort_count: got %0d expected 1", abort_cnt); end
    n_checks++; if (rx_valid_cnt !== 0) begin n_fail++; $display("[TB] FAIL collision_rx_valid_count: got %0d expected 0", rx_valid_cnt); end
    n_checks++; if (rx_data_o !== 16'h8001) begin n_fail++; $display("[TB] FAIL collision_rx_hold: got %h expected 8001", rx_data_o); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_idle_noise();
    test_reset_mid_word();
    test_cs_sclk_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
